// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divider: operand width,
// divide op encodings and the divider FSM state type.
package rv32m_pkg;

  localparam int XLEN    = 32;
  localparam int COUNT_W = $clog2(XLEN);

  typedef logic [4:0] alu_op_t;

  localparam alu_op_t OP_DIV  = 5'b01111;
  localparam alu_op_t OP_DIVU = 5'b10000;
  localparam alu_op_t OP_REM  = 5'b10001;
  localparam alu_op_t OP_REMU = 5'b10010;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/iterative_divider_if.sv
// EX-stage <-> divider bundle: start request, operands, result and stall.
interface iterative_divider_if;
  import rv32m_pkg::*;

  logic            div_use;
  logic            flush;
  alu_op_t         alu_opE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic [XLEN-1:0] result_d;
  logic            flagD;
  logic            stall_div;

  // Pipeline side: issues ops, consumes results
  modport master (
    output div_use, flush, alu_opE, SrcAE, SrcBE,
    input  result_d, flagD, stall_div
  );

  // Divider side
  modport slave (
    input  div_use, flush, alu_opE, SrcAE, SrcBE,
    output result_d, flagD, stall_div
  );
endinterface

// File: rtl/iterative_divider_div_step.sv
// One radix-2 restoring division iteration: shift {rem,quo} left by one,
// subtract the divisor when it fits and record the quotient bit.
module div_step
  import rv32m_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  // Shifted partial remainder can briefly need XLEN+1 bits
  logic [XLEN:0] w_rem_sh;
  logic          w_fits;

  assign w_rem_sh = {i_rem, i_quo[XLEN-1]};
  assign w_fits   = (w_rem_sh >= {1'b0, i_divisor});

  // Restore (keep shifted value) or subtract, and shift in the quotient bit
  always_comb begin
    o_rem = w_rem_sh[XLEN-1:0];
    o_quo = {i_quo[XLEN-2:0], 1'b0};
    if (w_fits) begin
      o_rem = w_rem_sh[XLEN-1:0] - i_divisor;
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow
// bypass the iteration and deliver their fixed result one cycle after start.
module iterative_divider
  import rv32m_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  iterative_divider_if.slave  bus
);

  div_state_t         r_state;
  logic [COUNT_W-1:0] r_count;
  alu_op_t            r_op;
  logic [XLEN-1:0]    r_quo;
  logic [XLEN-1:0]    r_rem;
  logic [XLEN-1:0]    r_divisor;
  logic [XLEN-1:0]    r_dividend;
  logic               r_qsign;
  logic               r_rsign;
  logic               r_div0;
  logic               r_ovf;

  logic               w_op_valid;
  logic               w_signed_op;
  logic               w_start;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [XLEN-1:0]    w_a_abs;
  logic [XLEN-1:0]    w_b_abs;
  logic               w_div0;
  logic               w_ovf;
  logic               w_early;
  logic [XLEN-1:0]    w_next_rem;
  logic [XLEN-1:0]    w_next_quo;
  logic [XLEN-1:0]    w_quo_fix;
  logic [XLEN-1:0]    w_rem_fix;
  logic [XLEN-1:0]    w_result;
  logic               w_done;

  assign w_op_valid  = (bus.alu_opE == OP_DIV) || (bus.alu_opE == OP_DIVU) ||
                       (bus.alu_opE == OP_REM) || (bus.alu_opE == OP_REMU);
  assign w_signed_op = (bus.alu_opE == OP_DIV) || (bus.alu_opE == OP_REM);
  // Non-divide opcodes never start, so they also never stall the pipeline
  assign w_start     = (r_state == IDLE) && bus.div_use && !bus.flush && w_op_valid;

  assign w_a_neg = w_signed_op && bus.SrcAE[XLEN-1];
  assign w_b_neg = w_signed_op && bus.SrcBE[XLEN-1];
  assign w_a_abs = w_a_neg ? (~bus.SrcAE + 1'b1) : bus.SrcAE;
  assign w_b_abs = w_b_neg ? (~bus.SrcBE + 1'b1) : bus.SrcBE;
  assign w_div0  = (bus.SrcBE == '0);
  assign w_ovf   = w_signed_op && (bus.SrcAE == INT_MIN) && (&bus.SrcBE);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = w_div0 || w_ovf;
`else
  assign w_early = 1'b0;
`endif

  div_step u_div_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_quo     (w_next_quo)
  );

  // FSM, iteration counter and operand/sign registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_op       <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_divisor  <= '0;
      r_dividend <= '0;
      r_qsign    <= 1'b0;
      r_rsign    <= 1'b0;
      r_div0     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op       <= bus.alu_opE;
            r_quo      <= w_a_abs;
            r_rem      <= '0;
            r_divisor  <= w_b_abs;
            r_dividend <= bus.SrcAE;
            r_qsign    <= w_a_neg ^ w_b_neg;
            r_rsign    <= w_a_neg;
            r_div0     <= w_div0;
            r_ovf      <= w_ovf;
            r_count    <= '0;
            r_state    <= w_early ? DONE : CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= w_next_rem;
            r_quo   <= w_next_quo;
            r_count <= r_count + 1'b1;
            if (r_count == COUNT_W'(XLEN-1))
              r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sign correction; negating a zero remainder naturally yields zero
  assign w_quo_fix = r_qsign ? (~r_quo + 1'b1) : r_quo;
  assign w_rem_fix = r_rsign ? (~r_rem + 1'b1) : r_rem;

  // Result select with the architecturally fixed special cases
  always_comb begin
    w_result = '0;
    if ((r_op == OP_DIV) || (r_op == OP_DIVU)) begin
      if (r_div0)     w_result = '1;
      else if (r_ovf) w_result = INT_MIN;
      else            w_result = w_quo_fix;
    end else begin
      if (r_div0)     w_result = r_dividend;
      else if (r_ovf) w_result = '0;
      else            w_result = w_rem_fix;
    end
  end

  // A flush in DONE suppresses the result; a flush in CALC releases the stall at once
  assign w_done        = (r_state == DONE) && !bus.flush;
  assign bus.flagD     = w_done;
  assign bus.result_d  = w_done ? w_result : '0;
  assign bus.stall_div = w_start || ((r_state == CALC) && !bus.flush);

endmodule

// File: tb/tb_iterative_divider.sv
// Directed self-checking bench for iterative_divider.
module tb_iterative_divider;
  import rv32m_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 33;
`endif

  iterative_divider_if dif ();

  iterative_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op and wait (bounded) for its flagD pulse
  task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    dif.div_use = 1'b1;
    dif.alu_opE = op;
    dif.SrcAE   = a;
    dif.SrcBE   = b;
    @(posedge clk);
    #1 dif.div_use = 1'b0;
    lat = -1;
    res = 32'hDEAD_BEEF;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (dif.flagD) begin
        res = dif.result_d;
        lat = i;
        break;
      end
    end
    $display("op=%b a=%h b=%h -> result=%h latency=%0d", op, a, b, res, lat);
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (dif.flagD !== 1'b0) begin n_fail++; $display("FAIL reset_flagD: got %b expected 0", dif.flagD); end
    n_checks++;
    if (dif.result_d !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", dif.result_d); end
    n_checks++;
    if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", dif.stall_div); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic;
    logic [31:0] res;
    int lat;
    run_op(OP_DIV, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd14) begin n_fail++; $display("FAIL div_100_7: got %h expected %h", res, 32'd14); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", lat); end
    @(negedge clk);
    n_checks++;
    if (dif.flagD !== 1'b0 || dif.result_d !== 32'h0) begin
      n_fail++; $display("FAIL flag_one_cycle: got flagD=%b result=%h expected 0/0", dif.flagD, dif.result_d);
    end
    run_op(OP_REM, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd2) begin n_fail++; $display("FAIL rem_100_7: got %h expected %h", res, 32'd2); end
  endtask

  task automatic test_signed;
    logic [31:0] res;
    int lat;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2: got %h expected FFFFFFFD", res); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2: got %h expected FFFFFFFF", res); end
    run_op(OP_DIVU, 32'hFFFF_FFF9, 32'd2, res, lat);
    n_checks++;
    if (res !== 32'h7FFF_FFFC) begin n_fail++; $display("FAIL divu_big_2: got %h expected 7FFFFFFC", res); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2: got %h expected FFFFFFFD", res); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, res, lat);
    n_checks++;
    if (res !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2: got %h expected 00000001", res); end
    run_op(OP_REMU, 32'd1000, 32'd10, res, lat);
    n_checks++;
    if (res !== 32'd0) begin n_fail++; $display("FAIL remu_zero_rem: got %h expected 00000000", res); end
  endtask

  task automatic test_div_zero;
    logic [31:0] res;
    int lat;
    run_op(OP_DIV, 32'd5, 32'd0, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_5_0: got %h expected FFFFFFFF", res); end
    n_checks++;
    if (lat !== LAT_SPECIAL) begin n_fail++; $display("FAIL div0_latency: got %0d expected %0d", lat, LAT_SPECIAL); end
    run_op(OP_REMU, 32'd5, 32'd0, res, lat);
    n_checks++;
    if (res !== 32'd5) begin n_fail++; $display("FAIL remu_5_0: got %h expected 00000005", res); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, res, lat);
    n_checks++;
    if (res !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL rem_m7_0: got %h expected FFFFFFF9", res); end
  endtask

  task automatic test_overflow;
    logic [31:0] res;
    int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h expected 80000000", res); end
    n_checks++;
    if (lat !== LAT_SPECIAL) begin n_fail++; $display("FAIL ovf_latency: got %0d expected %0d", lat, LAT_SPECIAL); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    n_checks++;
    if (res !== 32'h0) begin n_fail++; $display("FAIL rem_ovf: got %h expected 00000000", res); end
  endtask

  task automatic test_rst_mid;
    int seen;
    @(negedge clk);
    dif.div_use = 1'b1; dif.alu_opE = OP_DIVU; dif.SrcAE = 32'd100; dif.SrcBE = 32'd7;
    @(posedge clk);
    #1 dif.div_use = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (dif.stall_div !== 1'b1) begin n_fail++; $display("FAIL calc_stall: got %b expected 1", dif.stall_div); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (dif.stall_div !== 1'b0 || dif.flagD !== 1'b0 || dif.result_d !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got stall=%b flagD=%b result=%h expected 0/0/0",
                         dif.stall_div, dif.flagD, dif.result_d);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.flagD || dif.stall_div) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", seen); end
    $display("reset mid-op: active cycles after reset=%0d", seen);
  endtask

  task automatic test_flush;
    int seen;
    logic [31:0] res;
    int lat;
    @(negedge clk);
    dif.div_use = 1'b1; dif.alu_opE = OP_DIV; dif.SrcAE = 32'd100; dif.SrcBE = 32'd7;
    @(posedge clk);
    #1 dif.div_use = 1'b0;
    repeat (5) @(negedge clk);
    dif.flush = 1'b1;
    #1;
    n_checks++;
    if (dif.stall_div !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", dif.stall_div); end
    @(posedge clk);
    #1 dif.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.flagD) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL flush_no_flag: got %0d pulses expected 0", seen); end
    $display("flush mid-op: flagD pulses=%0d", seen);
    run_op(OP_DIV, 32'd100, 32'd7, res, lat);
    n_checks++;
    if (res !== 32'd14 || lat !== 33) begin
      n_fail++; $display("FAIL after_flush: got %h lat %0d expected 0000000e lat 33", res, lat);
    end
  endtask

  task automatic test_back_to_back;
    int n1, n2, pulses;
    logic [31:0] r1, r2;
    n1 = -1; n2 = -1; pulses = 0; r1 = '0; r2 = '0;
    @(negedge clk);
    dif.div_use = 1'b1; dif.alu_opE = OP_DIVU; dif.SrcAE = 32'd100; dif.SrcBE = 32'd7;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (dif.flagD) begin
        pulses++;
        if (n1 < 0) begin n1 = i; r1 = dif.result_d; end
        else if (n2 < 0) begin n2 = i; r2 = dif.result_d; end
      end
      if (n1 > 0 && i == n1 + 1) begin
        n_checks++;
        if (dif.stall_div !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_stall: got %b expected 1", dif.stall_div); end
      end
      if (n1 > 0 && i == n1 + 2) dif.div_use = 1'b0;
    end
    dif.div_use = 1'b0;
    $display("back-to-back: pulses=%0d first=%0d (%h) second=%0d (%h)", pulses, n1, r1, n2, r2);
    n_checks++;
    if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    n_checks++;
    if (n1 !== 33 || n2 !== 67) begin n_fail++; $display("FAIL b2b_timing: got %0d/%0d expected 33/67", n1, n2); end
    n_checks++;
    if (r1 !== 32'd14 || r2 !== 32'd14) begin n_fail++; $display("FAIL b2b_result: got %h/%h expected 0000000e", r1, r2); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    dif.div_use = 1'b0;
    dif.flush   = 1'b0;
    dif.alu_opE = '0;
    dif.SrcAE   = '0;
    dif.SrcBE   = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_rst_mid();
    test_flush();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
